// File: rtl/epb_sync_slave.sv
// EPB asynchronous-bus slave bridged onto a synchronous register bus.
// Only chip select and output enable are synchronized; the other pad inputs are stable while cs_n is low.
module epb_sync_slave #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] TIMEOUT_RDATA  = 16'hDEAD
) (
  input  logic        epb_clk,
  input  logic        epb_rst,
  input  logic        epb_cs_n,
  input  logic        epb_oe_n,
  input  logic        epb_r_w_n,
  input  logic [1:0]  epb_be_n,
  input  logic [22:0] epb_addr,
  input  logic [5:0]  epb_addr_gp,
  input  logic [15:0] epb_data_in_i,
  output logic [15:0] epb_data_out_o,
  output logic        epb_data_oe_n_o,
  output logic        epb_rdy,
  output logic        epb_rdy_oe,
  output logic        bus_req,
  output logic        bus_rnw,
  output logic [28:0] bus_addr,
  output logic [1:0]  bus_be,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, WAIT_CS} state_t;

  localparam logic [15:0] TO_LIM = TIMEOUT_CYCLES[15:0];

  state_t      state_q, state_d;
  logic        cs_meta_q, cs_s_q, oe_meta_q, oe_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        rnw_q, rnw_d;
  logic [28:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rdy_q, rdy_d;
  logic        rdy_oe_q, rdy_oe_d;
  logic        data_oe_n_q, data_oe_n_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rdy_d     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_s_q) begin
          state_d = REQ;
          req_d   = 1'b1;
          cnt_d   = 16'd0;
          addr_d  = {epb_addr_gp, epb_addr};
          rnw_d   = epb_r_w_n;
          be_d    = ~epb_be_n;
          wdata_d = epb_data_in_i;
        end
      end
      REQ: begin
        // Abort beats ack, and ack beats a timeout landing in the same cycle.
        if (cs_s_q) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdy_d   = 1'b1;
          if (rnw_q) rdata_d = bus_rdata;
        end else if (cnt_q + 16'd1 == TO_LIM) begin
          state_d   = DONE;
          req_d     = 1'b0;
          rdy_d     = 1'b1;
          timeout_d = 1'b1;
          cnt_d     = cnt_q + 16'd1;
          if (rnw_q) rdata_d = TIMEOUT_RDATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE:    state_d = WAIT_CS;
      WAIT_CS: if (cs_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_oe_d = (state_d != IDLE);
    // oe_meta_q is the value oe_s takes at the same edge, so the enable tracks oe_s exactly.
    data_oe_n_d = !(((state_d == DONE) || (state_d == WAIT_CS)) && rnw_d && !oe_meta_q);
  end

  always_ff @(posedge epb_clk) begin
    if (epb_rst) begin
      state_q     <= IDLE;
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
      oe_meta_q   <= 1'b1;
      oe_s_q      <= 1'b1;
      cnt_q       <= 16'd0;
      req_q       <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= 29'd0;
      be_q        <= 2'd0;
      wdata_q     <= 16'd0;
      rdata_q     <= 16'd0;
      rdy_q       <= 1'b0;
      rdy_oe_q    <= 1'b0;
      data_oe_n_q <= 1'b1;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_meta_q   <= epb_cs_n;
      cs_s_q      <= cs_meta_q;
      oe_meta_q   <= epb_oe_n;
      oe_s_q      <= oe_meta_q;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rdy_q       <= rdy_d;
      rdy_oe_q    <= rdy_oe_d;
      data_oe_n_q <= data_oe_n_d;
      timeout_q   <= timeout_d;
    end
  end

  assign epb_data_out_o  = rdata_q;
  assign epb_data_oe_n_o = data_oe_n_q;
  assign epb_rdy         = rdy_q;
  assign epb_rdy_oe      = rdy_oe_q;
  assign bus_req         = req_q;
  assign bus_rnw         = rnw_q;
  assign bus_addr        = addr_q;
  assign bus_be          = be_q;
  assign bus_wdata       = wdata_q;
  assign timeout_o       = timeout_q;

  // oe_s_q is kept as the visible synchronizer output; the enable uses its next value.
  logic unused_oe_s;
  assign unused_oe_s = oe_s_q;

endmodule

// File: tb/tb_epb_sync_slave.sv
// Directed bench for epb_sync_slave: write, read, timeout, ack/timeout tie, abort, back-to-back, reset mid-request.
module tb_epb_sync_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1, oe_n = 1'b1, r_w_n = 1'b0;
  logic [1:0]  be_n = 2'b11;
  logic [22:0] addr = '0;
  logic [5:0]  addr_gp = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_oe_n, rdy, rdy_oe, bus_req, bus_rnw, timeout;
  logic [28:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;

  int n_checks = 0;
  int n_fail = 0;
  int rdy_pulses = 0;
  int to_pulses = 0;

  epb_sync_slave #(.TIMEOUT_CYCLES(4), .TIMEOUT_RDATA(16'hDEAD)) dut (
    .epb_clk(clk), .epb_rst(rst), .epb_cs_n(cs_n), .epb_oe_n(oe_n),
    .epb_r_w_n(r_w_n), .epb_be_n(be_n), .epb_addr(addr), .epb_addr_gp(addr_gp),
    .epb_data_in_i(data_in), .epb_data_out_o(data_out), .epb_data_oe_n_o(data_oe_n),
    .epb_rdy(rdy), .epb_rdy_oe(rdy_oe), .bus_req(bus_req), .bus_rnw(bus_rnw),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .timeout_o(timeout)
  );

  // clock / pulse monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rdy === 1'b1) rdy_pulses++;
    if (timeout === 1'b1) to_pulses++;
  end

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the number of edges until bus_req is seen, or 99 if it never appears.
  task automatic wait_req(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_req === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus_req); end
    n_checks++; if (rdy !== 1'b0 || rdy_oe !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got rdy=%b oe=%b to=%b expected 0 0 0", rdy, rdy_oe, timeout); end
    n_checks++; if (data_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_doe: got %b expected 1", data_oe_n); end
    n_checks++; if (data_out !== 16'h0 || bus_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_data: got out=%h wdata=%h expected 0", data_out, bus_wdata); end
    n_checks++; if (bus_addr !== 29'h0 || bus_be !== 2'b00 || bus_rnw !== 1'b0) begin n_fail++; $display("FAIL reset_bus: got addr=%h be=%b rnw=%b expected 0", bus_addr, bus_be, bus_rnw); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write;
    int n, r0, t0;
    r0 = rdy_pulses; t0 = to_pulses;
    r_w_n = 1'b0; addr_gp = 6'h01; addr = 23'h000010; be_n = 2'b00; data_in = 16'hA5A5;
    cs_n = 1'b0;
    wait_req(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL write_latency: got %0d expected 3", n); end
    n_checks++; if (bus_addr !== 29'h00800010) begin n_fail++; $display("FAIL write_addr: got %h expected 00800010", bus_addr); end
    n_checks++; if (bus_be !== 2'b11 || bus_rnw !== 1'b0) begin n_fail++; $display("FAIL write_be_rnw: got be=%b rnw=%b expected 11 0", bus_be, bus_rnw); end
    n_checks++; if (bus_wdata !== 16'hA5A5) begin n_fail++; $display("FAIL write_wdata: got %h expected a5a5", bus_wdata); end
    n_checks++; if (rdy_oe !== 1'b1) begin n_fail++; $display("FAIL write_rdy_oe: got %b expected 1", rdy_oe); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus_req !== 1'b1 || bus_addr !== 29'h00800010 || bus_wdata !== 16'hA5A5) begin n_fail++; $display("FAIL write_hold: got req=%b addr=%h wdata=%h expected 1 00800010 a5a5", bus_req, bus_addr, bus_wdata); end
    end
    // Ack lands on the 4th request cycle, where the wait counter also expires.
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    n_checks++; if (rdy !== 1'b1 || bus_req !== 1'b0 || data_oe_n !== 1'b1) begin n_fail++; $display("FAIL write_done: got rdy=%b req=%b doe=%b expected 1 0 1", rdy, bus_req, data_oe_n); end
    tick();
    n_checks++; if (rdy !== 1'b0 || rdy_oe !== 1'b1) begin n_fail++; $display("FAIL write_wait: got rdy=%b rdy_oe=%b expected 0 1", rdy, rdy_oe); end
    cs_n = 1'b1;
    tick(3);
    n_checks++; if (rdy_oe !== 1'b0) begin n_fail++; $display("FAIL write_idle: got rdy_oe=%b expected 0", rdy_oe); end
    n_checks++; if (rdy_pulses - r0 !== 1 || to_pulses - t0 !== 0) begin n_fail++; $display("FAIL write_pulses: got rdy=%0d to=%0d expected 1 0", rdy_pulses - r0, to_pulses - t0); end
    n_checks++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL write_no_latch: got %h expected 0000", data_out); end
  endtask

  task automatic test_read;
    int n;
    r_w_n = 1'b1; oe_n = 1'b0; addr_gp = 6'h00; addr = 23'h000020; be_n = 2'b01; bus_rdata = 16'h1234;
    cs_n = 1'b0;
    wait_req(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL read_latency: got %0d expected 3", n); end
    n_checks++; if (bus_rnw !== 1'b1 || bus_be !== 2'b10 || bus_addr !== 29'h20) begin n_fail++; $display("FAIL read_bus: got rnw=%b be=%b addr=%h expected 1 10 20", bus_rnw, bus_be, bus_addr); end
    n_checks++; if (data_oe_n !== 1'b1) begin n_fail++; $display("FAIL read_doe_req: got %b expected 1", data_oe_n); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    n_checks++; if (rdy !== 1'b1 || data_out !== 16'h1234 || data_oe_n !== 1'b0) begin n_fail++; $display("FAIL read_done: got rdy=%b out=%h doe=%b expected 1 1234 0", rdy, data_out, data_oe_n); end
    oe_n = 1'b1;
    tick(2);
    n_checks++; if (data_oe_n !== 1'b1) begin n_fail++; $display("FAIL read_oe_off: got %b expected 1", data_oe_n); end
    oe_n = 1'b0;
    tick(2);
    n_checks++; if (data_oe_n !== 1'b0) begin n_fail++; $display("FAIL read_oe_on: got %b expected 0", data_oe_n); end
    cs_n = 1'b1;
    tick(2);
    n_checks++; if (data_oe_n !== 1'b0) begin n_fail++; $display("FAIL read_doe_hold: got %b expected 0", data_oe_n); end
    tick();
    n_checks++; if (data_oe_n !== 1'b1 || data_out !== 16'h1234) begin n_fail++; $display("FAIL read_release: got doe=%b out=%h expected 1 1234", data_oe_n, data_out); end
    oe_n = 1'b1;
    tick(2);
  endtask

  task automatic test_timeout;
    int n, r0, t0;
    r0 = rdy_pulses; t0 = to_pulses;
    r_w_n = 1'b1; oe_n = 1'b0; addr = 23'h000040; be_n = 2'b00; bus_rdata = 16'h7777;
    cs_n = 1'b0;
    wait_req(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 3", n); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus_req !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_req_high: got req=%b to=%b expected 1 0", bus_req, timeout); end
    end
    tick();
    n_checks++; if (bus_req !== 1'b0 || timeout !== 1'b1 || rdy !== 1'b1) begin n_fail++; $display("FAIL timeout_fire: got req=%b to=%b rdy=%b expected 0 1 1", bus_req, timeout, rdy); end
    n_checks++; if (data_out !== 16'hDEAD) begin n_fail++; $display("FAIL timeout_rdata: got %h expected dead", data_out); end
    tick();
    n_checks++; if (timeout !== 1'b0 || rdy !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_len: got to=%b rdy=%b expected 0 0", timeout, rdy); end
    cs_n = 1'b1; oe_n = 1'b1;
    tick(3);
    n_checks++; if (rdy_pulses - r0 !== 1 || to_pulses - t0 !== 1) begin n_fail++; $display("FAIL timeout_pulses: got rdy=%0d to=%0d expected 1 1", rdy_pulses - r0, to_pulses - t0); end
  endtask

  task automatic test_ack_timeout_tie;
    int n, t0;
    t0 = to_pulses;
    r_w_n = 1'b1; addr = 23'h000050; bus_rdata = 16'h5A5A;
    cs_n = 1'b0;
    wait_req(n);
    tick(3);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    n_checks++; if (rdy !== 1'b1 || timeout !== 1'b0 || data_out !== 16'h5A5A) begin n_fail++; $display("FAIL tie_ack_wins: got rdy=%b to=%b out=%h expected 1 0 5a5a", rdy, timeout, data_out); end
    cs_n = 1'b1;
    tick(3);
    n_checks++; if (to_pulses - t0 !== 0) begin n_fail++; $display("FAIL tie_no_timeout: got %0d pulses expected 0", to_pulses - t0); end
  endtask

  task automatic test_abort;
    int n, r0, t0;
    r0 = rdy_pulses; t0 = to_pulses;
    r_w_n = 1'b1; oe_n = 1'b0; addr = 23'h000060; bus_rdata = 16'hBAD0;
    cs_n = 1'b0;
    wait_req(n);
    cs_n = 1'b1;
    tick(2);
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL abort_sync_delay: got req=%b expected 1", bus_req); end
    tick();
    n_checks++; if (bus_req !== 1'b0 || rdy_oe !== 1'b0) begin n_fail++; $display("FAIL abort_drop: got req=%b rdy_oe=%b expected 0 0", bus_req, rdy_oe); end
    tick(2);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick(3);
    n_checks++; if (bus_req !== 1'b0 || rdy_oe !== 1'b0 || data_out !== 16'h5A5A) begin n_fail++; $display("FAIL abort_late_ack: got req=%b rdy_oe=%b out=%h expected 0 0 5a5a", bus_req, rdy_oe, data_out); end
    n_checks++; if (rdy_pulses - r0 !== 0 || to_pulses - t0 !== 0) begin n_fail++; $display("FAIL abort_pulses: got rdy=%0d to=%0d expected 0 0", rdy_pulses - r0, to_pulses - t0); end
    oe_n = 1'b1;
    tick(2);
  endtask

  task automatic test_back_to_back;
    int n, r0, extra_req;
    r0 = rdy_pulses; extra_req = 0;
    r_w_n = 1'b0; addr_gp = 6'h02; addr = 23'h000001; be_n = 2'b10; data_in = 16'h1111;
    cs_n = 1'b0;
    wait_req(n);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_first_rdy: got %b expected 1", rdy); end
    addr = 23'h000002; data_in = 16'h2222; be_n = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_req !== 1'b0) extra_req++;
    end
    n_checks++; if (extra_req !== 0 || rdy_oe !== 1'b1) begin n_fail++; $display("FAIL b2b_held_cs: got %0d req cycles rdy_oe=%b expected 0 1", extra_req, rdy_oe); end
    cs_n = 1'b1;
    tick(3);
    cs_n = 1'b0;
    wait_req(n);
    n_checks++; if (n !== 3 || bus_addr !== 29'h01000002) begin n_fail++; $display("FAIL b2b_second_req: got n=%0d addr=%h expected 3 01000002", n, bus_addr); end
    n_checks++; if (bus_wdata !== 16'h2222 || bus_be !== 2'b10) begin n_fail++; $display("FAIL b2b_second_data: got wdata=%h be=%b expected 2222 10", bus_wdata, bus_be); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    cs_n = 1'b1;
    tick(3);
    n_checks++; if (rdy_pulses - r0 !== 2 || data_out !== 16'h5A5A) begin n_fail++; $display("FAIL b2b_pulses: got rdy=%0d out=%h expected 2 5a5a", rdy_pulses - r0, data_out); end
  endtask

  task automatic test_reset_mid_req;
    int n, r0;
    r0 = rdy_pulses;
    r_w_n = 1'b1; oe_n = 1'b0; addr_gp = 6'h00; addr = 23'h000033; be_n = 2'b00; bus_rdata = 16'h0BEE;
    cs_n = 1'b0;
    wait_req(n);
    rst = 1'b1;
    tick();
    n_checks++; if (bus_req !== 1'b0 || rdy_oe !== 1'b0 || rdy !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got req=%b rdy_oe=%b rdy=%b to=%b expected 0 0 0 0", bus_req, rdy_oe, rdy, timeout); end
    n_checks++; if (data_out !== 16'h0 || bus_addr !== 29'h0 || data_oe_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_data: got out=%h addr=%h doe=%b expected 0 0 1", data_out, bus_addr, data_oe_n); end
    rst = 1'b0;
    wait_req(n);
    n_checks++; if (n !== 3 || bus_addr !== 29'h33) begin n_fail++; $display("FAIL rstmid_restart: got n=%0d addr=%h expected 3 33", n, bus_addr); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    n_checks++; if (rdy !== 1'b1 || data_out !== 16'h0BEE || data_oe_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_complete: got rdy=%b out=%h doe=%b expected 1 0bee 0", rdy, data_out, data_oe_n); end
    cs_n = 1'b1; oe_n = 1'b1;
    tick(3);
    n_checks++; if (rdy_pulses - r0 !== 1) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 1", rdy_pulses - r0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_timeout_tie();
    test_abort();
    test_back_to_back();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
